// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM generator: counting-mode encoding
// and default parameter values.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwmMode_e;

  localparam int DEF_WIDTH    = 11;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DEADTIME = 4;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: registered compare of the shared counter against this channel's duty.
// With PWM_COMPLEMENT_EN defined it also drives a complementary output with dead-time.
module pwm_chan import pwm_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH
`ifdef PWM_COMPLEMENT_EN
  , parameter int DEADTIME = DEF_DEADTIME
`endif
) (
  input  logic             Clk_pwm,
  input  logic             Rst,
  input  logic             run,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm
`ifdef PWM_COMPLEMENT_EN
  , output logic           pwmN
`endif
);

  logic cmp;
  assign cmp = run & (count < duty);

`ifdef PWM_COMPLEMENT_EN
  localparam logic [WIDTH-1:0] DT  = DEADTIME[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             rawQ;
  logic [WIDTH-1:0] dt;
  logic [WIDTH-1:0] dtNext;
  logic             settled;

  // dt counts clocks since the last change of the raw compare, saturating at DT
  always_comb begin
    dtNext = dt;
    if (cmp != rawQ) begin
      dtNext = '0;
    end else if (dt != DT) begin
      dtNext = dt + ONE;
    end
  end

  assign settled = (dtNext == DT);

  always_ff @(posedge Clk_pwm or posedge Rst) begin
    if (Rst) begin
      rawQ <= 1'b0;
      dt   <= DT;
      pwm  <= 1'b0;
      pwmN <= 1'b0;
    end else begin
      rawQ <= cmp;
      dt   <= dtNext;
      pwm  <= cmp & settled;
      pwmN <= ~cmp & run & settled;
    end
  end
`else
  always_ff @(posedge Clk_pwm or posedge Rst) begin
    if (Rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= cmp;
    end
  end
`endif

endmodule

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: shared edge/center counter, double-buffered duty with
// valid/ready load, atomic update at period boundaries. PWM_COMPLEMENT_EN adds PwmSigN.
module pwm_gen_mc import pwm_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEADTIME = DEF_DEADTIME
) (
  input  logic                      Clk_pwm,
  input  logic                      Rst,
  input  logic                      Enable,
  input  logic                      Mode,
  input  logic [CHANNELS*WIDTH-1:0] DutyVec,
  input  logic                      DutyValid,
  output logic                      DutyReady,
  output logic [CHANNELS-1:0]       PwmSig,
  output logic                      PeriodStart
`ifdef PWM_COMPLEMENT_EN
  , output logic [CHANNELS-1:0]     PwmSigN
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2 || CHANNELS < 1 || DEADTIME < 0 || DEADTIME >= 2**WIDTH) begin : gBadParams
    $error("pwm_gen_mc: parameter out of range");
  end

  logic [WIDTH-1:0]          cnt;
  logic [WIDTH-1:0]          cntNext;
  logic                      dirUp;
  logic                      dirNext;
  pwmMode_e                  modeReg;
  pwmMode_e                  stepMode;
  logic [CHANNELS*WIDTH-1:0] activeDuty;
  logic [CHANNELS*WIDTH-1:0] pending;
  logic [CHANNELS*WIDTH-1:0] effDuty;
  logic                      pendFull;
  logic                      boundary;
  logic                      loadActive;

  assign boundary   = Enable && (cnt == '0) && (modeReg == MODE_EDGE || dirUp);
  assign loadActive = boundary && pendFull;
  assign stepMode   = boundary ? pwmMode_e'(Mode) : modeReg;
  // The period that starts at a boundary already compares against the newly loaded duty
  assign effDuty    = loadActive ? pending : activeDuty;
  assign DutyReady  = ~pendFull;

  always_comb begin
    cntNext = cnt;
    dirNext = dirUp;
    if (!Enable) begin
      cntNext = '0;
      dirNext = 1'b1;
    end else if (stepMode == MODE_CENTER) begin
      if (dirUp) begin
        if (cnt == CNT_MAX) begin
          cntNext = CNT_MAX - CNT_ONE;
          dirNext = 1'b0;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end else begin
        cntNext = cnt - CNT_ONE;
        dirNext = (cnt == CNT_ONE);
      end
    end else begin
      cntNext = cnt + CNT_ONE;
      dirNext = 1'b1;
    end
  end

  always_ff @(posedge Clk_pwm or posedge Rst) begin
    if (Rst) begin
      cnt         <= '0;
      dirUp       <= 1'b1;
      modeReg     <= MODE_EDGE;
      activeDuty  <= '0;
      pending     <= '0;
      pendFull    <= 1'b0;
      PeriodStart <= 1'b0;
    end else begin
      cnt         <= cntNext;
      dirUp       <= dirNext;
      PeriodStart <= boundary;
      if (boundary) begin
        modeReg <= pwmMode_e'(Mode);
      end
      if (loadActive) begin
        activeDuty <= pending;
      end
      // Capture and boundary drain are exclusive: capture needs the buffer empty
      if (DutyValid && DutyReady) begin
        pending  <= DutyVec;
        pendFull <= 1'b1;
      end else if (loadActive) begin
        pendFull <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : gChan
    pwm_chan #(
      .WIDTH(WIDTH)
`ifdef PWM_COMPLEMENT_EN
      , .DEADTIME(DEADTIME)
`endif
    ) uChan (
      .Clk_pwm(Clk_pwm),
      .Rst(Rst),
      .run(Enable),
      .count(cnt),
      .duty(effDuty[k*WIDTH +: WIDTH]),
      .pwm(PwmSig[k])
`ifdef PWM_COMPLEMENT_EN
      , .pwmN(PwmSigN[k])
`endif
    );
  end

endmodule
